// File: rtl/kernel_pooler_pkg.sv
// kernel_pooler_pkg: shared flat-bus indexing helper for the pooling engine.
package kernel_pooler_pkg;
    function automatic int flat_idx(input int major, input int minor, input int minor_n);
        return major * minor_n + minor;
    endfunction
endpackage

// File: rtl/kernel_pooler_window_max.sv
// window_max: unsigned maximum of N packed DEPTH-bit values via a balanced comparator tree.
module window_max #(
    parameter int DEPTH = 8,
    parameter int N     = 9
) (
    input  logic [N*DEPTH-1:0] din_i,
    output logic [DEPTH-1:0]   max_o
);
    localparam int P = 1 << $clog2(N);

    // Heap-ordered tree: leaves at P..2P-1, zero padding is neutral for unsigned max.
    logic [DEPTH-1:0] t [1:2*P-1];

    always_comb begin
        for (int k = 0; k < P; k++)
            t[P+k] = (k < N) ? din_i[k*DEPTH +: DEPTH] : '0;
        for (int k = P - 1; k >= 1; k--)
            t[k] = (t[2*k] > t[2*k+1]) ? t[2*k] : t[2*k+1];
    end

    assign max_o = t[1];
endmodule

// File: rtl/kernel_pooler.sv
// kernel_pooler: registered KXxKY stride-1 max pooling over a flat AXxAY matrix.
module kernel_pooler
    import kernel_pooler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int KX    = 3,
    parameter int KY    = 3,
    parameter int AX    = 8,
    parameter int AY    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [DEPTH*AX*AY-1:0]             A,
    output logic                               out_valid,
    output logic [DEPTH*(AX-KX+1)*(AY-KY+1)-1:0] B
);
    localparam int OX = AX - KX + 1;
    localparam int OY = AY - KY + 1;
    localparam int N  = KX * KY;

    if (KX > AX || KY > AY) begin : g_bad_window
        $error("kernel_pooler: window larger than matrix");
    end

    logic [DEPTH*OX*OY-1:0] b_d, b_q;
    logic                   out_valid_q;

    // A is row-major (x fastest), B is x-major (j fastest).
    for (genvar i = 0; i < OX; i++) begin : g_x
        for (genvar j = 0; j < OY; j++) begin : g_y
            logic [N*DEPTH-1:0] win;
            for (genvar u = 0; u < KX; u++) begin : g_u
                for (genvar v = 0; v < KY; v++) begin : g_v
                    assign win[(v*KX+u)*DEPTH +: DEPTH] = A[flat_idx(j+v, i+u, AX)*DEPTH +: DEPTH];
                end
            end
            window_max #(.DEPTH(DEPTH), .N(N)) u_max (
                .din_i (win),
                .max_o (b_d[flat_idx(i, j, OY)*DEPTH +: DEPTH])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) b_q <= b_d;
        end
    end

    assign B         = b_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_kernel_pooler.sv
// tb_kernel_pooler: checks three pooler configurations (3x3, 1x1, 8x8) against a window-max model.
module tb_kernel_pooler;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic [511:0] A = '0;
    logic         ov3, ov1, ov8;
    logic [287:0] b3;
    logic [511:0] b1;
    logic [7:0]   b8;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    kernel_pooler u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .out_valid(ov3), .B(b3));
    kernel_pooler #(.KX(1), .KY(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .out_valid(ov1), .B(b1));
    kernel_pooler #(.KX(8), .KY(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .out_valid(ov8), .B(b8));

    typedef struct { int i; int j; int exp; } pt_t;
    pt_t pts [6];

    function automatic int elem(input logic [511:0] a, input int x, input int y);
        return int'(a[(y*8+x)*8 +: 8]);
    endfunction

    function automatic int ref_max(input logic [511:0] a, input int kx, input int ky, input int i, input int j);
        int m = 0;
        for (int x = i; x < i + kx; x++)
            for (int y = j; y < j + ky; y++)
                if (elem(a, x, y) > m) m = elem(a, x, y);
        return m;
    endfunction

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [511:0] a, input bit zero, input bit ov_exp);
        cmp({tag, " ov3"}, int'(ov3), int'(ov_exp));
        cmp({tag, " ov1"}, int'(ov1), int'(ov_exp));
        cmp({tag, " ov8"}, int'(ov8), int'(ov_exp));
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                cmp($sformatf("%s b3(%0d,%0d)", tag, i, j), int'(b3[(i*6+j)*8 +: 8]), zero ? 0 : ref_max(a, 3, 3, i, j));
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                cmp($sformatf("%s b1(%0d,%0d)", tag, i, j), int'(b1[(i*8+j)*8 +: 8]), zero ? 0 : ref_max(a, 1, 1, i, j));
        cmp({tag, " b8"}, int'(b8), zero ? 0 : ref_max(a, 8, 8, 0, 0));
    endtask

    task automatic pulse(input logic [511:0] a);
        A = a;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    function automatic logic [511:0] pattern1();
        logic [511:0] a;
        int v;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                case (y)
                    0, 1, 2, 3: v = 39 - 8*y - x;
                    4:          v = (x < 7) ? 7 - x : 250;
                    default:    v = 240 - 80*(y-5) - 10*x;
                endcase
                a[(y*8+x)*8 +: 8] = 8'(v);
            end
        return a;
    endfunction

    function automatic logic [511:0] rand_mat();
        logic [511:0] a;
        for (int k = 0; k < 64; k++) a[k*8 +: 8] = 8'($urandom);
        return a;
    endfunction

    initial begin
        logic [511:0] p1, hot, r1, r2, last;
        bit iv;
        pts = '{'{0,0,39}, '{3,1,28}, '{0,3,240}, '{0,5,240}, '{5,2,250}, '{5,5,190}};
        p1 = pattern1();
        #2;
        check_all("reset", '0, 1, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        check_all("idle", '0, 1, 0);

        pulse(p1);
        check_all("p1", p1, 0, 1);
        for (int k = 0; k < 6; k++)
            cmp($sformatf("p1 pt(%0d,%0d)", pts[k].i, pts[k].j), int'(b3[(pts[k].i*6+pts[k].j)*8 +: 8]), pts[k].exp);
        cmp("p1 global", int'(b8), 250);
        @(posedge clk); #1;
        check_all("p1 hold", p1, 0, 0);

        pulse({64{8'hFF}});
        check_all("ones", {64{8'hFF}}, 0, 1);
        pulse('0);
        check_all("zeros", '0, 0, 1);

        hot = '0;
        hot[(4*8+4)*8 +: 8] = 8'd200;
        pulse(hot);
        check_all("hot", hot, 0, 1);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                cmp($sformatf("hot cov(%0d,%0d)", i, j), int'(b3[(i*6+j)*8 +: 8]),
                    (i >= 2 && i <= 4 && j >= 2 && j <= 4) ? 200 : 0);

        #3 rst_n = 0;
        #1 check_all("async rst", '0, 1, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        check_all("post rst idle", '0, 1, 0);
        r1 = rand_mat();
        pulse(r1);
        check_all("post rst", r1, 0, 1);
        @(posedge clk); #1;
        check_all("post rst hold", r1, 0, 0);

        r1 = rand_mat();
        r2 = rand_mat();
        A = r1; in_valid = 1;
        @(posedge clk); #1;
        check_all("b2b first", r1, 0, 1);
        A = r2;
        @(posedge clk); #1;
        check_all("b2b second", r2, 0, 1);
        in_valid = 0;
        @(posedge clk); #1;
        check_all("b2b hold", r2, 0, 0);

        last = r2;
        for (int n = 0; n < 30; n++) begin
            iv = 1'($urandom);
            r1 = rand_mat();
            A = r1; in_valid = iv;
            @(posedge clk); #1;
            if (iv) last = r1;
            check_all($sformatf("rnd%0d", n), last, 0, iv);
        end
        in_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_pooler.md
Name: kernel_pooler

Overview:
- Registered 2-D max-pooling engine. Slides a KX×KY window with stride 1 and no padding over an AX×AY matrix of unsigned DEPTH-bit elements, and emits one maximum per window position.
- Full matrix arrives as one flat bus; full result leaves as one flat bus.
- Sits after a convolution/feature stage in the CNN datapath.

Parameters:
- DEPTH, 8: element width in bits (unsigned).
- KX, 3: window width (x / column direction); 1 ≤ KX ≤ AX.
- KY, 3: window height (y / row direction); 1 ≤ KY ≤ AY.
- AX, 8: input matrix width (columns).
- AY, 8: input matrix height (rows).
- Derived localparams: OX = AX-KX+1, OY = AY-KY+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  A holds a matrix to pool this cycle.
- A  in  DEPTH*AX*AY  input matrix; element (x,y) = A[(y*AX+x)*DEPTH +: DEPTH], x in 0..AX-1, y in 0..AY-1 (row-major, x fastest).
- out_valid  out  1  B updated with a new result.
- B  out  DEPTH*OX*OY  pooled matrix; result (i,j) = B[(i*OY+j)*DEPTH +: DEPTH], i in 0..OX-1, j in 0..OY-1 (x-major, j fastest — note differs from A).

Behaviour:
- Result definition: B(i,j) = max of A(x,y) for x in i..i+KX-1 and y in j..j+KY-1.
  - Unsigned compare.
  - Ties are irrelevant, since the value is the same.
  - No saturation or width growth; output width equals DEPTH.
- Max computation is purely combinational from A; all OX*OY windows are evaluated in parallel.
- Output register: on rising clk with in_valid=1, B is loaded with the window maxima and out_valid is set to 1.
- Latency is 1 cycle; throughput is one matrix per cycle.
- With in_valid=0, B holds its last value and out_valid goes to 0 on the next edge.
- out_valid is a single-cycle pulse per accepted input. Back-to-back in_valid yields out_valid held high.
- No backpressure; the consumer must capture B while out_valid=1.
- Reset: rst_n low asynchronously forces B=0 and out_valid=0 immediately, regardless of clk.
  - Reset mid-stream discards any pending result.
  - First valid result after release appears one edge after the first in_valid sampled high with rst_n high.
- Boundary cases:
  - KX=AX and KY=AY gives a single output equal to the global max.
  - KX=KY=1 gives B = A, re-indexed to the output ordering.
- Elaboration check: the design must fail elaboration (generate-time error) if KX>AX or KY>AY.

Decomposition:
- Shared package (cnn_pkg): no typedefs required; optional helper function for the flat-index calculation.
- Sub-module window_max: parameters DEPTH, N=KX*KY; input N*DEPTH bus; output the DEPTH-bit maximum via a balanced comparator tree.
  - Instantiated OX*OY times inside generate loops.
  - kernel_pooler does the window gathering and the output registers.

Test Plan:
- Default params. Load A with row y=0: x0..7 = 39,38,…,32; y=1: 31..24; y=2: 23..16; y=3: 15..8; y=4: 7,6,5,4,3,2,1,250; y=5: 240,230,…,170; y=6: 160,…,90; y=7: 80,…,10. Pulse in_valid. One cycle later, with out_valid=1, require:
  - B(0,0)=39
  - B(3,1)=28
  - B(0,3)=240
  - B(0,5)=240
  - B(5,2)=250
  - B(5,5)=190
- All elements 255 -> every B element 255. All elements 0 -> every B element 0.
- Single hot element A(4,4)=200, others 0 -> B(i,j)=200 exactly for i,j in 2..4, else 0. This checks window coverage and index ordering.
- Assert rst_n low mid-cycle after a valid result -> B=0 and out_valid=0 immediately. Release, then in_valid for 1 cycle -> out_valid high for exactly 1 cycle with the correct B.
- Two consecutive matrices with in_valid high 2 cycles -> out_valid high 2 cycles, with B matching each input in order.
- Params KX=KY=1 -> B(i,j) = A(i,j). Params KX=KY=8 -> single output = global max (250 for the first pattern).
